// File: rtl/pdm_serializer_if.sv
// PCM sample handshake into the PDM serializer.
// Transfer happens on a clock edge where valid & ready.
interface pdm_serializer_if #(
  parameter int SAMPLE_W = 16
);
  logic [SAMPLE_W-1:0] sample;
  logic                valid;
  logic                ready;

  modport master (
    output sample,
    output valid,
    input  ready
  );

  modport slave (
    input  sample,
    input  valid,
    output ready
  );
endinterface

// File: rtl/pdm_serializer.sv
// PCM to PDM transmit path: divided bit clock plus a first-order
// sigma-delta 1-bit stream, with one sample buffered ahead.
module pdm_serializer #(
  parameter int DIV      = 100,
  parameter int SAMPLE_W = 16,
  parameter int OSR      = 64
) (
  input  logic            clock_i,
  input  logic            reset_i,
  input  logic            enable_i,
  pdm_serializer_if.slave s_if,
  output logic            pdm_clk_o,
  output logic            pdm_data_o,
  output logic            underrun_o
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(OSR);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [BW-1:0] OSR_LAST = BW'(OSR - 1);
  localparam logic [SAMPLE_W-1:0] MSB =
    {1'b1, {(SAMPLE_W-1){1'b0}}};

  logic [DW-1:0]       div_cnt;
  logic [BW-1:0]       bit_cnt;
  logic [SAMPLE_W-1:0] acc;
  logic [SAMPLE_W-1:0] active;
  logic [SAMPLE_W-1:0] hold;
  logic                hold_full;

  logic                tick;
  logic                fall;
  logic                boundary;
  logic [SAMPLE_W-1:0] u;
  logic [SAMPLE_W:0]   acc_next;

  assign tick     = enable_i & (div_cnt == DIV_LAST);
  assign fall     = tick & pdm_clk_o;
  assign boundary = fall & (bit_cnt == OSR_LAST);

  // Offset binary: signed midscale maps to half of full scale.
  assign u        = active ^ MSB;
  assign acc_next = {1'b0, acc} + {1'b0, u};

  assign s_if.ready = ~hold_full;

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      div_cnt    <= '0;
      bit_cnt    <= '0;
      acc        <= '0;
      active     <= '0;
      hold       <= '0;
      hold_full  <= 1'b0;
      pdm_clk_o  <= 1'b0;
      pdm_data_o <= 1'b0;
      underrun_o <= 1'b0;
    end else begin
      underrun_o <= 1'b0;

      if (!enable_i) begin
        div_cnt    <= '0;
        bit_cnt    <= '0;
        acc        <= '0;
        pdm_clk_o  <= 1'b0;
        pdm_data_o <= 1'b0;
      end else begin
        if (tick) begin
          div_cnt   <= '0;
          pdm_clk_o <= ~pdm_clk_o;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end

        if (fall) begin
          pdm_data_o <= acc_next[SAMPLE_W];
          acc        <= acc_next[SAMPLE_W-1:0];
          bit_cnt    <= boundary ? '0 : bit_cnt + 1'b1;
        end

        // Empty hold at a boundary plays silence, not the old sample.
        if (boundary) begin
          if (hold_full) begin
            active <= hold;
          end else begin
            active     <= '0;
            underrun_o <= 1'b1;
          end
        end
      end

      if (boundary && hold_full) begin
        hold_full <= 1'b0;
      end else if (s_if.valid && !hold_full) begin
        hold      <= s_if.sample;
        hold_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pdm_serializer.sv
// Scoreboard bench: stimulus queues expected PDM bits, a monitor
// pops one at every pdm_clk rise and checks underrun spacing.
module tb_pdm_serializer;
  localparam int DIV  = 2;
  localparam int OSR  = 4;
  localparam int SW   = 16;
  localparam int SPER = 2 * DIV * OSR;

  logic clock_i  = 1'b0;
  logic reset_i  = 1'b0;
  logic enable_i = 1'b0;
  logic pdm_clk_o;
  logic pdm_data_o;
  logic underrun_o;

  pdm_serializer_if #(.SAMPLE_W(SW)) bif ();

  pdm_serializer #(
    .DIV(DIV),
    .SAMPLE_W(SW),
    .OSR(OSR)
  ) dut (
    .clock_i(clock_i),
    .reset_i(reset_i),
    .enable_i(enable_i),
    .s_if(bif),
    .pdm_clk_o(pdm_clk_o),
    .pdm_data_o(pdm_data_o),
    .underrun_o(underrun_o)
  );

  always #5 clock_i = ~clock_i;

  int cyc = 0;
  always @(posedge clock_i) cyc <= cyc + 1;

  int   n_cmp = 0;
  int   n_bad = 0;
  logic exp_q[$];
  logic exp_bit;
  bit   chk_en = 1'b0;
  logic clk_q = 1'b0;
  int   n_rise = 0;
  int   rise1 = 0;
  int   rise2 = 0;
  int   ur_cnt = 0;
  int   ur_last = 0;
  int   ur_gap = 0;
  int   ones_cnt = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  always @(negedge clock_i) begin
    if (pdm_clk_o && !clk_q) begin
      n_rise++;
      if (n_rise == 1) rise1 = cyc;
      else if (n_rise == 2) rise2 = cyc;
      if (chk_en) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_empty: bit %0b with nothing expected",
                   pdm_data_o);
        end else begin
          exp_bit = exp_q.pop_front();
          if (pdm_data_o === 1'b1) ones_cnt++;
          check("pdm_bit", {31'd0, pdm_data_o}, {31'd0, exp_bit});
        end
      end
    end
    clk_q = pdm_clk_o;
    if (underrun_o) begin
      ur_cnt++;
      ur_gap  = cyc - ur_last;
      ur_last = cyc;
    end
  end

  // Bit 3 goes out first. Starting from acc=0 each of these
  // leaves acc=0 after four bits, except 0x7FFF.
  function automatic logic [3:0] pat_of(input logic [SW-1:0] v,
                                        input bit first);
    case (v)
      16'h8000: return 4'b0000;
      16'hC000: return 4'b0001;
      16'h0000: return 4'b0101;
      16'h4000: return 4'b0111;
      16'h7FFF: return first ? 4'b0111 : 4'b1111;
      default:  return 4'b0000;
    endcase
  endfunction

  task automatic push_pat(input logic [3:0] p);
    for (int i = 3; i >= 0; i--) exp_q.push_back(p[i]);
  endtask

  task automatic seg_start();
    int r;
    int g;
    chk_en = 1'b0;
    bif.valid = 1'b0;
    @(negedge clock_i);
    reset_i  = 1'b0;
    enable_i = 1'b1;
    repeat (3) @(negedge clock_i);
    check("rst_clk", {31'd0, pdm_clk_o}, 32'd0);
    check("rst_data", {31'd0, pdm_data_o}, 32'd0);
    check("rst_underrun", {31'd0, underrun_o}, 32'd0);
    check("rst_ready", {31'd0, bif.ready}, 32'd1);
    exp_q.delete();
    // First rise still shows the reset data value.
    exp_q.push_back(1'b0);
    push_pat(4'b0101);
    n_rise   = 0;
    ur_cnt   = 0;
    ur_last  = 0;
    ones_cnt = 0;
    r        = cyc;
    chk_en   = 1'b1;
    reset_i  = 1'b1;
    g = 0;
    while (n_rise < 2 && g < 40) begin
      @(negedge clock_i);
      g++;
    end
    if (n_rise < 2) begin
      n_cmp++;
      n_bad++;
      $display("FAIL clk_timeout: %0d rises seen, need 2", n_rise);
    end else begin
      check("first_rise", rise1 - r, DIV);
      check("clk_period", rise2 - rise1, 2 * DIV);
    end
  endtask

  task automatic feed(input logic [SW-1:0] v0,
                      input logic [SW-1:0] step,
                      input int n);
    logic [SW-1:0] v;
    int sent;
    int g;
    int last;
    v = v0;
    sent = 0;
    g = 0;
    last = 0;
    while (sent < n && g < (n + 2) * SPER) begin
      @(negedge clock_i);
      g++;
      bif.sample = v;
      bif.valid  = 1'b1;
      if (bif.ready) begin
        push_pat(pat_of(v, sent == 0));
        if (sent >= 2) check("xfer_gap", cyc - last, SPER);
        last = cyc;
        sent++;
        v = v + step;
      end
    end
    if (sent < n) begin
      n_cmp++;
      n_bad++;
      $display("FAIL feed_timeout: sent %0d need %0d", sent, n);
    end
    @(negedge clock_i);
    bif.valid = 1'b0;
    check("feed_no_underrun", ur_cnt, 0);
  endtask

  task automatic seg_end(input int ur_exp);
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 400) begin
      @(negedge clock_i);
      g++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sb_drain: got %0d bits left expected 0",
               exp_q.size());
    end
    chk_en = 1'b0;
    check("underruns", ur_cnt, ur_exp);
  endtask

  initial begin
    int r;
    int g;
    bif.valid  = 1'b0;
    bif.sample = '0;

    // Midscale: one preload, then three silent underrun periods.
    seg_start();
    feed(16'h0000, 16'h0000, 1);
    repeat (3) push_pat(4'b0101);
    seg_end(4);
    check("ur_gap", ur_gap, SPER);

    // Extremes.
    seg_start();
    feed(16'h8000, 16'h0000, 6);
    seg_end(1);
    seg_start();
    feed(16'h7FFF, 16'h0000, 6);
    seg_end(1);

    // Density: 64 samples x 4 bits of u=0xC000.
    seg_start();
    feed(16'h4000, 16'h0000, 64);
    seg_end(1);
    // Midscale lead-in period adds 2 ones to the 192.
    check("ones_density", ones_cnt, 2 + 192);

    // Backpressure with valid held high, stepping by 0x4000.
    seg_start();
    feed(16'h8000, 16'h4000, 8);
    seg_end(1);

    // Enable drop mid-sample with a sample buffered.
    seg_start();
    feed(16'h8000, 16'h0000, 1);
    g = 0;
    while (!(pdm_clk_o && pdm_data_o) && g < 40) begin
      @(negedge clock_i);
      g++;
    end
    check("dis_setup_data", {31'd0, pdm_data_o}, 32'd1);
    chk_en = 1'b0;
    exp_q.delete();
    enable_i = 1'b0;
    @(negedge clock_i);
    check("dis_clk", {31'd0, pdm_clk_o}, 32'd0);
    check("dis_data", {31'd0, pdm_data_o}, 32'd0);
    check("dis_hold_kept", {31'd0, bif.ready}, 32'd0);
    repeat (6) @(negedge clock_i);
    check("dis_idle_clk", {31'd0, pdm_clk_o}, 32'd0);
    check("dis_no_underrun", ur_cnt, 0);
    exp_q.push_back(1'b0);
    push_pat(4'b0101);
    push_pat(4'b0000);
    n_rise = 0;
    r = cyc;
    chk_en = 1'b1;
    enable_i = 1'b1;
    g = 0;
    while (n_rise < 1 && g < 40) begin
      @(negedge clock_i);
      g++;
    end
    check("reen_first_rise", rise1 - r, DIV);
    seg_end(1);

    // Async reset mid-sample discards the buffered sample.
    seg_start();
    feed(16'hC000, 16'h0000, 3);
    chk_en = 1'b0;
    check("pre_rst_ready", {31'd0, bif.ready}, 32'd0);
    @(posedge clock_i);
    #2;
    reset_i = 1'b0;
    #1;
    check("arst_clk", {31'd0, pdm_clk_o}, 32'd0);
    check("arst_data", {31'd0, pdm_data_o}, 32'd0);
    check("arst_underrun", {31'd0, underrun_o}, 32'd0);
    check("arst_ready", {31'd0, bif.ready}, 32'd1);
    seg_start();
    push_pat(4'b0101);
    seg_end(2);
    check("arst_ur_gap", ur_gap, SPER);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pdm_serializer.md
# pdm_serializer

Transmit-side counterpart of the recorder's PDM input path: accepts signed PCM samples over a valid/ready handshake and drives a PDM bit clock plus a first-order sigma-delta 1-bit data stream to the audio output (amplifier/filter pin or a loopback PDM receiver). It generates its own bit clock from `clock_i` with a programmable divider. It buffers one sample ahead so the upstream playback reader has a full sample period to respond.

## Interface
- `DIV`, 100 — `clock_i` cycles per half period of `pdm_clk_o` (≥1).
- `SAMPLE_W`, 16 — PCM sample width, two's complement.
- `OSR`, 64 — PDM bits emitted per PCM sample (≥2).
- `clock_i`  in  1  system clock; all logic on its rising edge.
- `reset_i`  in  1  asynchronous, active-low reset.
- `enable_i`  in  1  run/stop; low = synchronous idle.
- `sample_i`  in  SAMPLE_W  signed PCM sample.
- `valid_i`  in  1  `sample_i` valid.
- `ready_o`  out  1  holding register empty; transfer when `valid_i & ready_o`.
- `pdm_clk_o`  out  1  PDM bit clock, 50% duty, period 2·DIV cycles.
- `pdm_data_o`  out  1  PDM data, stable around each `pdm_clk_o` rise.
- `underrun_o`  out  1  one-cycle pulse: sample boundary with holding register empty.

## Operation
- Reset values (async, `reset_i` low): `pdm_clk_o`=0, `pdm_data_o`=0, `underrun_o`=0, `ready_o`=1 (hold empty). Divider=0, bit count=0, accumulator=0, active sample=0 (signed midscale).
- Divider counts 0..DIV-1 while `enable_i`=1. At terminal count it wraps to 0 and toggles `pdm_clk_o`.
- Fall event = the cycle `pdm_clk_o` toggles 1→0. All data-path updates happen only on fall events.
- On each fall event:
  - u = active sample with MSB inverted (offset binary).
  - acc_next = {0, acc[SAMPLE_W-1:0]} + {0, u}, SAMPLE_W+1 bits.
  - `pdm_data_o` ← acc_next[SAMPLE_W]; acc ← acc_next[SAMPLE_W-1:0].
  - Bit count increments.
- Sample boundary = a fall event with bit count = OSR-1. Bit count wraps to 0, then:
  - hold full: active ← hold, hold marked empty;
  - hold empty: active ← 0 (midscale/silence) and `underrun_o` pulses that cycle.
  - The new active sample applies from the next fall event.
- Accumulator is never cleared at sample boundaries.
- Handshake: `ready_o` = ~hold_full, registered state only, no combinational path from `valid_i`.
  - Transfer writes `sample_i` into hold; `ready_o` drops the next cycle.
  - Hold is never overwritten while full.
- `enable_i`=0, applied synchronously: divider, bit count and accumulator cleared; `pdm_clk_o`=0 and `pdm_data_o`=0.
  - Hold register and handshake keep working; no underrun pulses.
  - On re-enable, the first fall event occurs after 2·DIV cycles.
- Reset mid-sample: immediate return to the reset values above; any buffered sample is discarded.

## Timing
- `pdm_clk_o` rises DIV cycles after enable (or after reset release with `enable_i` high), then toggles every DIV cycles.
- `pdm_data_o` changes only in the same cycle `pdm_clk_o` falls, giving DIV cycles of setup and hold around each rise.
- Sample period = OSR·2·DIV cycles. `ready_o` reasserts the cycle after a boundary that consumes hold.
- Upstream must transfer within one sample period of `ready_o` rising to avoid underrun.
- Ones density over N bits ≈ u/2^SAMPLE_W. Full negative (0x8000) gives all zeros; 0x7FFF gives one 0 per 2^SAMPLE_W bits.

## Test plan
- Reset/idle (DIV=2, OSR=4): hold `reset_i` low → all outputs at reset values. Release with `enable_i`=1 → `pdm_clk_o` period 4 cycles, first rise 2 cycles after release.
- Midscale: preload 0x0000, no further input → data after each fall event is 0,1,0,1,…. `underrun_o` pulses at every later boundary (every 16 cycles).
- Extremes: feed 0x8000 continuously → `pdm_data_o` stays 0. Feed 0x7FFF continuously → all ones once the accumulator settles. `underrun_o` never pulses and `ready_o` toggles once per sample.
- Density (defaults): 0x4000 (u=0xC000) for 4 samples → exactly 192 of 256 bits are 1.
- Backpressure: hold `valid_i` high with incrementing data → one transfer per sample period. No sample is dropped or duplicated; order is preserved on the active sample.
- Enable/reset mid-operation: drop `enable_i` mid-sample → outputs 0 next cycle and the buffered sample is retained. Pulse `reset_i` low mid-sample → async clear and `ready_o`=1.
